win_gen_3x3: RTL and testbench

Streaming 3x3 sliding-window generator that sits directly upstream of the 3x3 FP16 convolution stage. It accepts one 16-bit pixel per handshake in raster order and buffers the two previous rows in line buffers. For every valid stride-1, unpadded window position it presents the nine pixels as one packed 144-bit word, pulses `conv_ready`, then holds that word stable until the convolution stage reports completion. Pixels are opaque 16-bit words: no arithmetic is performed on them.

---
 rtl/win_gen_3x3.sv | 153 +++++++++++++++
 tb/tb_win_gen_3x3.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/win_gen_3x3.sv
// win_gen_3x3: streaming 3x3 sliding-window generator feeding the 3x3 conv stage.
// Accepts one 16-bit pixel per handshake in raster order, keeps the two previous
// rows in line buffers and presents each stride-1 unpadded window as a packed
// 144-bit word, held until the convolution stage reports completion.
//
// Ports:
//   clk        - clock, all state updates on the rising edge
//   rst        - asynchronous active-high reset
//   pix_in     - incoming pixel (raster order)
//   pix_valid  - pix_in is valid
//   pix_ready  - block accepts a pixel this cycle
//   im         - packed window, element k = 3r+c at bits [16k+15:16k], r=0 top row, c=0 left
//   conv_ready - one-cycle pulse, im holds a new window
//   conv_done  - consumer finished the current window (sampled only in WAIT)
//   frame_done - one-cycle pulse after the last window of a frame is released
module win_gen_3x3 #(
    parameter int unsigned IMG_W = 8,
    parameter int unsigned IMG_H = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [15:0]  pix_in,
    input  logic         pix_valid,
    output logic         pix_ready,
    output logic [143:0] im,
    output logic         conv_ready,
    input  logic         conv_done,
    output logic         frame_done
);

    localparam int unsigned PIX_W = 16;
    localparam int unsigned COL_W = $clog2(IMG_W);
    localparam int unsigned ROW_W = $clog2(IMG_H);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [COL_W-1:0] col;
    logic [COL_W-1:0] col_next;
    logic [ROW_W-1:0] row;
    logic [ROW_W-1:0] row_next;

    // Line buffers: lb0 holds row-1, lb1 holds row-2 (not reset)
    logic [PIX_W-1:0] lb0 [IMG_W];
    logic [PIX_W-1:0] lb1 [IMG_W];

    // Window shift rows: w0 top, w1 middle, w2 bottom; index 2 is the newest column
    logic [PIX_W-1:0] w0 [3];
    logic [PIX_W-1:0] w1 [3];
    logic [PIX_W-1:0] w2 [3];

    logic accept;
    logic last_col;
    logic last_row;
    logic win_done;
    logic win_release;
    logic frame_last;

    // Next-state, counter advance and handshake decode
    always_comb begin
        state_next  = state;
        col_next    = col;
        row_next    = row;
        win_release = 1'b0;

        accept   = (state == LOAD) && pix_valid;
        last_col = (col == COL_W'(IMG_W - 1));
        last_row = (row == ROW_W'(IMG_H - 1));
        win_done = accept && (row >= ROW_W'(2)) && (col >= COL_W'(2));
        // In WAIT the counters sit at (0,0) only after the frame's final pixel
        // wrapped them; every other window leaves row or col nonzero.
        frame_last = (row == '0) && (col == '0);

        if (accept) begin
            if (last_col) begin
                col_next = '0;
                row_next = last_row ? '0 : row + ROW_W'(1);
            end else begin
                col_next = col + COL_W'(1);
            end
        end

        case (state)
            LOAD: begin
                if (win_done) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                state_next = WAIT;
            end
            WAIT: begin
                if (conv_done) begin
                    state_next  = LOAD;
                    win_release = 1'b1;
                end
            end
            default: begin
                state_next = LOAD;
            end
        endcase
    end

    // State, counters, window registers and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= LOAD;
            col        <= '0;
            row        <= '0;
            w0         <= '{default: '0};
            w1         <= '{default: '0};
            w2         <= '{default: '0};
            pix_ready  <= 1'b1;
            conv_ready <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_next;
            col        <= col_next;
            row        <= row_next;
            pix_ready  <= (state_next == LOAD);
            conv_ready <= (state_next == ISSUE);
            frame_done <= win_release && frame_last;
            if (accept) begin
                w2[0] <= w2[1];
                w2[1] <= w2[2];
                w2[2] <= pix_in;
                w1[0] <= w1[1];
                w1[1] <= w1[2];
                w1[2] <= lb0[col];
                w0[0] <= w0[1];
                w0[1] <= w0[2];
                w0[2] <= lb1[col];
            end
        end
    end

    // Line-buffer update; contents are never reset since windows are gated by row/col
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[col] <= lb0[col];
            lb0[col] <= pix_in;
        end
    end

    assign im = {w2[2], w2[1], w2[0], w1[2], w1[1], w1[0], w0[2], w0[1], w0[0]};

endmodule

// File: tb/tb_win_gen_3x3.sv
// tb_win_gen_3x3: self-checking bench for win_gen_3x3.
// Two instances (4x4 and 8x8) share clk/rst; 'sel' routes stimulus to one of them.
// Expected windows are cut directly out of the pixel stream in raster order of
// their bottom-right corner; handshake expectations follow the protocol timing.
module tb_win_gen_3x3;

    logic        clk;
    logic        rst;
    logic        sel;
    logic [15:0] pix_in;
    logic        pix_valid;
    logic        conv_done;

    logic         pr4, cr4, fd4;
    logic [143:0] im4;
    logic         pr8, cr8, fd8;
    logic [143:0] im8;

    win_gen_3x3 #(.IMG_W(4), .IMG_H(4)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid & ~sel),
        .pix_ready  (pr4),
        .im         (im4),
        .conv_ready (cr4),
        .conv_done  (conv_done & ~sel),
        .frame_done (fd4)
    );

    win_gen_3x3 #(.IMG_W(8), .IMG_H(8)) dut8 (
        .clk        (clk),
        .rst        (rst),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid & sel),
        .pix_ready  (pr8),
        .im         (im8),
        .conv_ready (cr8),
        .conv_done  (conv_done & sel),
        .frame_done (fd8)
    );

    wire         pr = sel ? pr8 : pr4;
    wire         cr = sel ? cr8 : cr4;
    wire         fd = sel ? fd8 : fd4;
    wire [143:0] im = sel ? im8 : im4;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // run-time model state
    int W, H, nwin_f, npix, total_win;
    int idx, since, rel_cnt, iss_cnt, dly, fd_cnt, cr_cnt, cyc;
    bit win_xfer, released, rel_last, gaps, early;
    logic [143:0] held;
    logic [15:0]  pix_q[$];
    logic [143:0] exp_q[$];
    logic [143:0] got_q[$];

    task automatic chk(input string tag, input logic [143:0] got, input logic [143:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // One clock cycle: check this cycle's outputs, then drive inputs for the next edge
    task automatic step();
        int p;
        @(negedge clk);
        if (win_xfer)      since = 0;
        else if (released) since = -1;
        else if (since >= 0) since++;

        chk("conv_ready", 144'(cr), 144'(since == 0));
        chk("pix_ready",  144'(pr), 144'(since < 0));
        chk("frame_done", 144'(fd), 144'(rel_last));
        if (cr) cr_cnt++;
        if (fd) fd_cnt++;
        if (since == 0) begin
            if (iss_cnt < exp_q.size()) chk($sformatf("window%0d", iss_cnt), im, exp_q[iss_cnt]);
            held = im;
            got_q.push_back(im);
            iss_cnt++;
        end else if (since >= 1) begin
            chk("held_im", im, held);
        end

        // consumer
        if (since >= 1)      conv_done = (since >= dly);
        else if (since == 0) conv_done = early;
        else                 conv_done = early ? 1'($urandom_range(0, 1)) : 1'b0;
        released = (since >= 1) && conv_done;
        rel_last = 1'b0;
        if (released) begin
            rel_cnt++;
            rel_last = ((rel_cnt % nwin_f) == 0);
        end

        // source
        win_xfer = 1'b0;
        if (idx < npix) begin
            pix_in    = pix_q[idx];
            pix_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (pix_valid && since < 0) begin
                p        = idx % (W * H);
                win_xfer = ((p / W) >= 2) && ((p % W) >= 2);
                idx++;
            end
        end else begin
            pix_valid = 1'b0;
            pix_in    = 16'($urandom);
        end
        cyc++;
    endtask

    // Stream nframes frames; abort_win>0 asserts rst during WAIT of that window
    task automatic run(input bit s, input int nframes, input bit randv, input bit g,
                       input bit e, input int d, input int abort_win);
        int fb;
        logic [143:0] wv;
        sel = s;
        W = s ? 8 : 4;
        H = W;
        nwin_f = (W - 2) * (H - 2);
        npix = nframes * W * H;
        total_win = nframes * nwin_f;
        gaps = g; early = e; dly = d;
        pix_q.delete(); exp_q.delete(); got_q.delete();
        for (int i = 0; i < npix; i++)
            pix_q.push_back(randv ? 16'($urandom) : 16'((i / (W * H)) * 256 + (i % (W * H))));
        for (int f = 0; f < nframes; f++) begin
            fb = f * W * H;
            for (int r = 2; r < H; r++)
                for (int c = 2; c < W; c++) begin
                    wv = '0;
                    for (int k = 0; k < 9; k++)
                        wv[16*k +: 16] = pix_q[fb + (r - 2 + k / 3) * W + (c - 2 + k % 3)];
                    exp_q.push_back(wv);
                end
        end
        idx = 0; since = -1; rel_cnt = 0; iss_cnt = 0; fd_cnt = 0; cr_cnt = 0; cyc = 0;
        win_xfer = 1'b0; released = 1'b0; rel_last = 1'b0;

        while (rel_cnt < total_win && cyc < 5000) begin
            step();
            if (abort_win > 0 && iss_cnt == abort_win && since >= 1) begin
                rst = 1'b1;
                #1;
                chk("async_rst_im", im, 144'h0);
                chk("async_rst_conv_ready", 144'(cr), 144'h0);
                return;
            end
        end
        if (cyc >= 5000) chk("timeout", 144'(1), 144'(0));
        repeat (3) step();
        chk("conv_ready_count", 144'(cr_cnt), 144'(total_win));
        chk("frame_done_count", 144'(fd_cnt), 144'(nframes));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pix_valid = 1'b0;
        conv_done = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_im4", im4, 144'h0);
        chk("rst_im8", im8, 144'h0);
        chk("rst_conv_ready", 144'({cr4, cr8}), 144'h0);
        chk("rst_frame_done", 144'({fd4, fd8}), 144'h0);
        chk("rst_pix_ready", 144'({pr4, pr8}), 144'h3);
    endtask

    localparam logic [143:0] BASIC_FIRST = {16'd10, 16'd9, 16'd8, 16'd6, 16'd5, 16'd4, 16'd2, 16'd1, 16'd0};
    localparam logic [143:0] BASIC_LAST  = {16'd15, 16'd14, 16'd13, 16'd11, 16'd10, 16'd9, 16'd7, 16'd6, 16'd5};
    localparam logic [143:0] F2_FIRST    = {16'h010A, 16'h0109, 16'h0108, 16'h0106, 16'h0105,
                                            16'h0104, 16'h0102, 16'h0101, 16'h0100};

    initial begin
        rst = 1'b1; sel = 1'b0; pix_in = '0; pix_valid = 1'b0; conv_done = 1'b0;
        do_reset();

        // basic 4x4 frame, conv_done two cycles after conv_ready
        run(1'b0, 1, 1'b0, 1'b0, 1'b0, 2, 0);
        chk("basic_count", 144'(got_q.size()), 144'(4));
        chk("basic_first", got_q[0], BASIC_FIRST);
        chk("basic_last", got_q[got_q.size() - 1], BASIC_LAST);

        // consumer stall of 20 cycles with pix_valid held high
        run(1'b0, 1, 1'b0, 1'b0, 1'b0, 20, 0);
        chk("stall_last", got_q[got_q.size() - 1], BASIC_LAST);

        // 8x8 random pixels with random upstream gaps, then gap-free
        run(1'b1, 1, 1'b1, 1'b1, 1'b0, 2, 0);
        chk("gaps_count", 144'(got_q.size()), 144'(36));
        run(1'b1, 1, 1'b1, 1'b0, 1'b0, 1, 0);

        // back-to-back 4x4 frames
        run(1'b0, 2, 1'b0, 1'b0, 1'b0, 2, 0);
        chk("b2b_f2_first", got_q[4], F2_FIRST);

        // reset during WAIT of the second window, then a fresh basic frame
        run(1'b0, 1, 1'b0, 1'b0, 1'b0, 30, 2);
        do_reset();
        run(1'b0, 1, 1'b0, 1'b0, 1'b0, 2, 0);
        chk("post_rst_first", got_q[0], BASIC_FIRST);
        chk("post_rst_last", got_q[got_q.size() - 1], BASIC_LAST);

        // early conv_done held through ISSUE (random elsewhere), 4x4 and 8x8 with gaps
        run(1'b0, 1, 1'b0, 1'b0, 1'b1, 1, 0);
        run(1'b1, 2, 1'b1, 1'b1, 1'b1, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
